// File: rtl/mspe_dispatch.sv
// rtl/mspe_dispatch.sv - whole-packet round-robin steering of the sink stream to one core
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   core_enable        per-core enable mask, looked at only when a packet starts
//   snk_*              ingress beat stream (data/valid/sop/eop, ready back)
//   dst_*              egress stream; data/sop/eop shared, valid one-hot per core,
//                      ready per core
//   cur_core           core owning the current or most recent packet
//   pkt_count          packets whose eop beat left the egress register
//   drop_count         beats discarded in IDLE because sop was missing
//   sop_err_count      sop beats seen inside a packet
module mspe_dispatch #(
    parameter int CORES  = 4,
    parameter int DATA_W = 512,
    parameter int CNT_W  = 32,
    localparam int IDX_W = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CORES-1:0]  core_enable,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_valid,
    input  logic              snk_sop,
    input  logic              snk_eop,
    output logic              snk_ready,
    output logic [DATA_W-1:0] dst_data,
    output logic [CORES-1:0]  dst_valid,
    output logic              dst_sop,
    output logic              dst_eop,
    input  logic [CORES-1:0]  dst_ready,
    output logic [IDX_W-1:0]  cur_core,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic [CNT_W-1:0]  sop_err_count
);

    typedef enum logic {IDLE, PASS} state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  last_q;
    logic [IDX_W-1:0]  sel_q;
    logic [IDX_W-1:0]  cur_core_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_sop_q;
    logic              out_eop_q;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [CNT_W-1:0]  pkt_count_q;
    logic [CNT_W-1:0]  drop_count_q;
    logic [CNT_W-1:0]  sop_err_count_q;

    logic              out_free;
    logic              egress_xfer;
    logic              accept;
    logic              load;
    logic [IDX_W-1:0]  grant;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign egress_xfer = out_valid_q & dst_ready[sel_q];
    assign out_free    = !out_valid_q | dst_ready[sel_q];

    // Gated by reset so the ingress never looks ready while the block is held.
    assign snk_ready = !reset &&
                       ((state_q == PASS) ? out_free : (out_free && (|core_enable)));
    assign accept    = snk_valid & snk_ready;

    // Only sop beats in IDLE or any beat in PASS reach the egress register;
    // sop-less beats in IDLE are swallowed.
    assign load = accept && ((state_q == PASS) || snk_sop);

    // Egress can drain and refill in the same cycle, keeping valid high.
    always_comb begin
        out_valid_d = out_valid_q;
        if (load) begin
            out_valid_d = 1'b1;
        end else if (egress_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    // Round-robin: first enabled core after the previous grant, with wrap.
    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= CORES; i++) begin
            idx = (int'(last_q) + i) % CORES;
            if (!found && core_enable[idx]) begin
                grant = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            last_q          <= IDX_W'(CORES - 1);
            sel_q           <= '0;
            cur_core_q      <= '0;
            out_data_q      <= '0;
            out_sop_q       <= 1'b0;
            out_eop_q       <= 1'b0;
            out_valid_q     <= 1'b0;
            pkt_count_q     <= '0;
            drop_count_q    <= '0;
            sop_err_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (egress_xfer && out_eop_q) begin
                pkt_count_q <= sat_inc(pkt_count_q);
            end
            if (accept) begin
                unique case (state_q)
                    IDLE: begin
                        if (snk_sop) begin
                            out_data_q <= snk_data;
                            out_sop_q  <= 1'b1;
                            out_eop_q  <= snk_eop;
                            sel_q      <= grant;
                            cur_core_q <= grant;
                            last_q     <= grant;
                            state_q    <= snk_eop ? IDLE : PASS;
                        end else begin
                            drop_count_q <= sat_inc(drop_count_q);
                        end
                    end
                    PASS: begin
                        // A stray sop mid-packet is forwarded as an ordinary beat.
                        out_data_q <= snk_data;
                        out_sop_q  <= 1'b0;
                        out_eop_q  <= snk_eop;
                        if (snk_sop) begin
                            sop_err_count_q <= sat_inc(sop_err_count_q);
                        end
                        if (snk_eop) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        dst_valid = '0;
        if (out_valid_q) begin
            dst_valid[sel_q] = 1'b1;
        end
    end

    assign dst_data      = out_data_q;
    assign dst_sop       = out_sop_q;
    assign dst_eop       = out_eop_q;
    assign cur_core      = cur_core_q;
    assign pkt_count     = pkt_count_q;
    assign drop_count    = drop_count_q;
    assign sop_err_count = sop_err_count_q;

endmodule

// File: tb/tb_mspe_dispatch.sv
// tb/tb_mspe_dispatch.sv - directed bench for mspe_dispatch
module tb_mspe_dispatch;

    localparam int CORES  = 4;
    localparam int DATA_W = 512;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [CORES-1:0]  core_enable;
    logic [DATA_W-1:0] snk_data;
    logic              snk_valid;
    logic              snk_sop;
    logic              snk_eop;
    logic              snk_ready;
    logic [DATA_W-1:0] dst_data;
    logic [CORES-1:0]  dst_valid;
    logic              dst_sop;
    logic              dst_eop;
    logic [CORES-1:0]  dst_ready;
    logic [1:0]        cur_core;
    logic [CNT_W-1:0]  pkt_count;
    logic [CNT_W-1:0]  drop_count;
    logic [CNT_W-1:0]  sop_err_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int                core;
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        int                cyc;
    } beat_t;

    beat_t mon_q[$];

    mspe_dispatch #(.CORES(CORES), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_enable  (core_enable),
        .snk_data     (snk_data),
        .snk_valid    (snk_valid),
        .snk_sop      (snk_sop),
        .snk_eop      (snk_eop),
        .snk_ready    (snk_ready),
        .dst_data     (dst_data),
        .dst_valid    (dst_valid),
        .dst_sop      (dst_sop),
        .dst_eop      (dst_eop),
        .dst_ready    (dst_ready),
        .cur_core     (cur_core),
        .pkt_count    (pkt_count),
        .drop_count   (drop_count),
        .sop_err_count(sop_err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Egress monitor: inputs change 1 time unit after posedge, so the
    // negedge view is what the next posedge will act on.
    always @(negedge clk) begin
        beat_t b;
        for (int c = 0; c < CORES; c++) begin
            if (dst_valid[c] && dst_ready[c]) begin
                b.core = c;
                b.data = dst_data;
                b.sop  = dst_sop;
                b.eop  = dst_eop;
                b.cyc  = cyc;
                mon_q.push_back(b);
            end
        end
    end

    function automatic logic [DATA_W-1:0] mk(input int k);
        return {16{32'(k)}};
    endfunction

    task automatic send(input int k, input logic s, input logic e, output int acc);
        snk_data  = mk(k);
        snk_sop   = s;
        snk_eop   = e;
        snk_valid = 1'b1;
        acc = -1;
        for (int n = 0; n < 50 && acc < 0; n++) begin
            @(negedge clk);
            if (snk_ready) acc = cyc;
            @(posedge clk);
            #1;
        end
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout beat=%0d accepted=0 required=1", k);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; core_enable = 4'hf; dst_ready = 4'hf;
        snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0; snk_data = '0;
        idle(3);
        @(negedge clk);
        checks++; if (snk_ready !== 1'b0) begin errors++; $display("FAIL rst_snk_ready got=%0b exp=0", snk_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (dst_valid !== 4'h0) begin errors++; $display("FAIL rst_dst_valid got=%0h exp=0", dst_valid); end
        checks++; if (dst_sop !== 1'b0 || dst_eop !== 1'b0) begin errors++; $display("FAIL rst_sop_eop got=%0b%0b exp=00", dst_sop, dst_eop); end
        checks++; if (dst_data !== '0) begin errors++; $display("FAIL rst_dst_data got=%0h exp=0", dst_data[31:0]); end
        checks++; if (cur_core !== 2'd0) begin errors++; $display("FAIL rst_cur_core got=%0d exp=0", cur_core); end
        checks++; if (pkt_count !== 0 || drop_count !== 0 || sop_err_count !== 0) begin
            errors++; $display("FAIL rst_counters got=%0d/%0d/%0d exp=0/0/0", pkt_count, drop_count, sop_err_count);
        end
    endtask

    task automatic test_round_robin;
        int accs[15];
        int p, b;
        core_enable = 4'hf; dst_ready = 4'hf;
        mon_q.delete();
        for (int i = 0; i < 15; i++) send(100 + (i / 3) * 10 + (i % 3), (i % 3) == 0, (i % 3) == 2, accs[i]);
        idle(3);
        checks++; if (mon_q.size() != 15) begin errors++; $display("FAIL rr_count got=%0d exp=15", mon_q.size()); end
        for (int i = 0; i < 15 && i < mon_q.size(); i++) begin
            p = i / 3; b = i % 3;
            checks++; if (mon_q[i].core != p % 4) begin errors++; $display("FAIL rr_core beat=%0d got=%0d exp=%0d", i, mon_q[i].core, p % 4); end
            checks++; if (mon_q[i].data !== mk(100 + p * 10 + b)) begin errors++; $display("FAIL rr_data beat=%0d got=%0d exp=%0d", i, mon_q[i].data[31:0], 100 + p * 10 + b); end
            checks++; if (mon_q[i].sop !== (b == 0)) begin errors++; $display("FAIL rr_sop beat=%0d got=%0b exp=%0b", i, mon_q[i].sop, b == 0); end
            checks++; if (mon_q[i].eop !== (b == 2)) begin errors++; $display("FAIL rr_eop beat=%0d got=%0b exp=%0b", i, mon_q[i].eop, b == 2); end
            checks++; if (mon_q[i].cyc != accs[i] + 1) begin errors++; $display("FAIL rr_latency beat=%0d got=%0d exp=1", i, mon_q[i].cyc - accs[i]); end
        end
        checks++; if (accs[14] - accs[0] != 14) begin errors++; $display("FAIL rr_throughput got=%0d exp=14", accs[14] - accs[0]); end
        checks++; if (pkt_count !== 5) begin errors++; $display("FAIL rr_pkt_count got=%0d exp=5", pkt_count); end
    endtask

    task automatic test_enable_mask;
        int exp_core[3] = '{1, 3, 1};
        int acc;
        core_enable = 4'b1010;
        mon_q.delete();
        for (int i = 0; i < 6; i++) send(200 + (i / 2) * 10 + (i % 2), (i % 2) == 0, (i % 2) == 1, acc);
        idle(3);
        checks++; if (mon_q.size() != 6) begin errors++; $display("FAIL mask_count got=%0d exp=6", mon_q.size()); end
        for (int i = 0; i < 6 && i < mon_q.size(); i++) begin
            checks++; if (mon_q[i].core != exp_core[i / 2]) begin errors++; $display("FAIL mask_core beat=%0d got=%0d exp=%0d", i, mon_q[i].core, exp_core[i / 2]); end
        end
        core_enable = 4'b0000;
        snk_data = mk(999); snk_sop = 1'b1; snk_eop = 1'b1; snk_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (snk_ready !== 1'b0) begin errors++; $display("FAIL mask_zero_ready cyc=%0d got=%0b exp=0", i, snk_ready); end
            @(posedge clk); #1;
        end
        snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
        core_enable = 4'hf;
        idle(2);
        checks++; if (mon_q.size() != 6) begin errors++; $display("FAIL mask_zero_taken got=%0d exp=6", mon_q.size()); end
        checks++; if (pkt_count !== 8) begin errors++; $display("FAIL mask_pkt_count got=%0d exp=8", pkt_count); end
        checks++; if (drop_count !== 0) begin errors++; $display("FAIL mask_drop_count got=%0d exp=0", drop_count); end
    endtask

    task automatic test_backpressure;
        int acc;
        core_enable = 4'hf; dst_ready = 4'hf;
        mon_q.delete();
        send(300, 1'b1, 1'b0, acc);
        send(301, 1'b0, 1'b0, acc);
        dst_ready = 4'b1011;
        snk_data = mk(302); snk_sop = 1'b0; snk_eop = 1'b0; snk_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (snk_ready !== 1'b0) begin errors++; $display("FAIL bp_snk_ready cyc=%0d got=%0b exp=0", i, snk_ready); end
            checks++; if (dst_valid !== 4'b0100) begin errors++; $display("FAIL bp_dst_valid cyc=%0d got=%0h exp=4", i, dst_valid); end
            checks++; if (dst_data !== mk(301)) begin errors++; $display("FAIL bp_dst_data cyc=%0d got=%0d exp=301", i, dst_data[31:0]); end
            @(posedge clk); #1;
        end
        dst_ready = 4'hf;
        snk_valid = 1'b0;
        send(302, 1'b0, 1'b0, acc);
        send(303, 1'b0, 1'b0, acc);
        send(304, 1'b0, 1'b1, acc);
        idle(3);
        checks++; if (mon_q.size() != 5) begin errors++; $display("FAIL bp_count got=%0d exp=5", mon_q.size()); end
        for (int i = 0; i < 5 && i < mon_q.size(); i++) begin
            checks++; if (mon_q[i].core != 2) begin errors++; $display("FAIL bp_core beat=%0d got=%0d exp=2", i, mon_q[i].core); end
            checks++; if (mon_q[i].data !== mk(300 + i)) begin errors++; $display("FAIL bp_data beat=%0d got=%0d exp=%0d", i, mon_q[i].data[31:0], 300 + i); end
            checks++; if (mon_q[i].sop !== (i == 0) || mon_q[i].eop !== (i == 4)) begin
                errors++; $display("FAIL bp_sop_eop beat=%0d got=%0b%0b exp=%0b%0b", i, mon_q[i].sop, mon_q[i].eop, i == 0, i == 4);
            end
        end
        checks++; if (pkt_count !== 9) begin errors++; $display("FAIL bp_pkt_count got=%0d exp=9", pkt_count); end
    endtask

    task automatic test_drop;
        int acc;
        mon_q.delete();
        send(400, 1'b0, 1'b0, acc);
        send(401, 1'b0, 1'b1, acc);
        idle(2);
        checks++; if (mon_q.size() != 0) begin errors++; $display("FAIL drop_output got=%0d exp=0", mon_q.size()); end
        checks++; if (drop_count !== 2) begin errors++; $display("FAIL drop_count got=%0d exp=2", drop_count); end
        send(402, 1'b1, 1'b1, acc);
        idle(2);
        checks++; if (mon_q.size() != 1) begin errors++; $display("FAIL drop_next_count got=%0d exp=1", mon_q.size()); end
        if (mon_q.size() > 0) begin
            checks++; if (mon_q[0].core != 3) begin errors++; $display("FAIL drop_next_core got=%0d exp=3", mon_q[0].core); end
            checks++; if (mon_q[0].sop !== 1'b1 || mon_q[0].eop !== 1'b1) begin errors++; $display("FAIL drop_next_sop_eop got=%0b%0b exp=11", mon_q[0].sop, mon_q[0].eop); end
        end
        checks++; if (cur_core !== 2'd3) begin errors++; $display("FAIL drop_cur_core got=%0d exp=3", cur_core); end
        checks++; if (pkt_count !== 10) begin errors++; $display("FAIL drop_pkt_count got=%0d exp=10", pkt_count); end
    endtask

    task automatic test_sop_err;
        int acc;
        mon_q.delete();
        send(500, 1'b1, 1'b0, acc);
        send(501, 1'b0, 1'b0, acc);
        send(502, 1'b1, 1'b0, acc);
        send(503, 1'b0, 1'b1, acc);
        idle(3);
        checks++; if (mon_q.size() != 4) begin errors++; $display("FAIL sop_err_beats got=%0d exp=4", mon_q.size()); end
        for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
            checks++; if (mon_q[i].core != 0) begin errors++; $display("FAIL sop_err_core beat=%0d got=%0d exp=0", i, mon_q[i].core); end
            checks++; if (mon_q[i].sop !== (i == 0)) begin errors++; $display("FAIL sop_err_sop beat=%0d got=%0b exp=%0b", i, mon_q[i].sop, i == 0); end
            checks++; if (mon_q[i].data !== mk(500 + i)) begin errors++; $display("FAIL sop_err_data beat=%0d got=%0d exp=%0d", i, mon_q[i].data[31:0], 500 + i); end
        end
        checks++; if (sop_err_count !== 1) begin errors++; $display("FAIL sop_err_count got=%0d exp=1", sop_err_count); end
        checks++; if (pkt_count !== 11) begin errors++; $display("FAIL sop_err_pkt_count got=%0d exp=11", pkt_count); end
    endtask

    task automatic test_reset_mid;
        int acc;
        send(600, 1'b1, 1'b0, acc);
        send(601, 1'b0, 1'b0, acc);
        checks++; if (cur_core !== 2'd1) begin errors++; $display("FAIL rmid_pre_core got=%0d exp=1", cur_core); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mon_q.delete();
        checks++; if (dst_valid !== 4'h0) begin errors++; $display("FAIL rmid_dst_valid got=%0h exp=0", dst_valid); end
        checks++; if (pkt_count !== 0 || drop_count !== 0 || sop_err_count !== 0) begin
            errors++; $display("FAIL rmid_counters got=%0d/%0d/%0d exp=0/0/0", pkt_count, drop_count, sop_err_count);
        end
        checks++; if (cur_core !== 2'd0) begin errors++; $display("FAIL rmid_cur_core got=%0d exp=0", cur_core); end
        send(602, 1'b0, 1'b0, acc);
        idle(2);
        checks++; if (drop_count !== 1) begin errors++; $display("FAIL rmid_drop got=%0d exp=1", drop_count); end
        send(603, 1'b1, 1'b0, acc);
        send(604, 1'b0, 1'b1, acc);
        idle(3);
        checks++; if (mon_q.size() != 2) begin errors++; $display("FAIL rmid_beats got=%0d exp=2", mon_q.size()); end
        for (int i = 0; i < 2 && i < mon_q.size(); i++) begin
            checks++; if (mon_q[i].core != 0) begin errors++; $display("FAIL rmid_core beat=%0d got=%0d exp=0", i, mon_q[i].core); end
        end
        checks++; if (pkt_count !== 1) begin errors++; $display("FAIL rmid_pkt_count got=%0d exp=1", pkt_count); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_enable_mask();
        test_backpressure();
        test_drop();
        test_sop_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mspe_dispatch.md
Name: mspe_dispatch

Overview:
- Ingress stage placed directly upstream of the multi-core packet engine's per-core sink FIFOs.
- Replaces broadcast of the 512-bit sink stream with whole-packet steering. Each packet (sop..eop) is delivered to exactly one enabled core, chosen round-robin.
- Provides a registered output stage, per-beat backpressure from the selected core, and error/packet counters for CSR readback.

Parameters:
- CORES, 4, number of destination cores; 1..32.
- DATA_W, 512, stream data width.
- CNT_W, 32, width of the statistic counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- core_enable  in  CORES  per-core enable mask (driven from the core run register); sampled only at packet start
- snk_data  in  DATA_W  ingress beat data
- snk_valid  in  1  ingress beat valid
- snk_sop  in  1  first beat of packet
- snk_eop  in  1  last beat of packet
- snk_ready  out  1  ingress accept; a beat transfers when snk_valid & snk_ready
- dst_data  out  DATA_W  egress data, shared by all cores
- dst_valid  out  CORES  one-hot egress valid; at most one bit set
- dst_sop  out  1  egress first beat
- dst_eop  out  1  egress last beat
- dst_ready  in  CORES  per-core accept (sink FIFO not full)
- cur_core  out  $clog2(CORES) (min 1)  core owning the current or last packet
- pkt_count  out  CNT_W  packets fully dispatched (eop beat transferred out)
- drop_count  out  CNT_W  beats dropped while IDLE because sop was missing
- sop_err_count  out  CNT_W  sop seen mid-packet

Behaviour:
- Reset values: snk_ready=0, dst_valid=0, dst_sop=0, dst_eop=0, dst_data=0, cur_core=0, all counters 0. Round-robin pointer last=CORES-1, so the first grant goes to the lowest enabled index. State is IDLE.
- Output stage: a single register holding {data, sop, eop, sel}.
  - out_free = !out_valid | dst_ready[sel].
  - Egress transfer when dst_valid[sel] & dst_ready[sel].
  - Ingress-to-egress latency is 1 cycle.
  - Full throughput of 1 beat/cycle when the target stays ready.
- FSM IDLE:
  - snk_ready = out_free & (core_enable != 0).
  - An accepted beat with sop=1 grants a core: the first core with core_enable set, searching from (last+1) mod CORES with wrap.
  - On grant: sel=cur_core=grant, last=grant, and the beat is loaded into the output register.
  - If that beat also has eop=1 (single-beat packet), stay in IDLE; otherwise go to PASS.
  - An accepted beat with sop=0 is discarded and drop_count increments. snk_ready is 1 for that beat provided out_free holds.
  - With core_enable==0, snk_ready=0; no drop occurs.
- FSM PASS:
  - snk_ready = out_free.
  - Accepted beats load the output register with sel unchanged.
  - An accepted beat with eop=1 returns the FSM to IDLE.
  - An accepted beat with sop=1 is forwarded with dst_sop forced to 0, and sop_err_count increments.
  - Changes to core_enable during PASS are ignored; the packet completes to its granted core.
- pkt_count increments on the egress transfer of a beat with eop=1.
- Counters saturate at all-ones; they do not wrap.
- Simultaneous egress transfer and ingress accept in the same cycle: the register is reloaded and dst_valid stays high.
- Reset mid-packet: the output register is cleared, the FSM returns to IDLE and the pointer is reinitialised.
  - The first post-reset beat without sop counts as a drop.

Test Plan:
- Back-to-back 3-beat packets, core_enable=4'b1111, dst_ready all 1 -> packets go to cores 0,1,2,3,0 in order. dst_sop on beat 1, dst_eop on beat 3, 1-cycle latency. pkt_count=5.
- core_enable=4'b1010 -> successive packets go to cores 1,3,1. Setting enable=0 between packets -> snk_ready=0 and no beats are taken.
- dst_ready[sel] deasserted for 4 cycles mid-packet -> dst_data/dst_valid are held and snk_ready=0. On resume no beat is lost or duplicated; the data sequence matches exactly.
- In IDLE, 2 beats with sop=0 -> both accepted, nothing is output, drop_count=2. The next sop packet is dispatched normally.
- 4-beat packet with sop asserted on beat 3 -> all 4 beats go to the same core, dst_sop only on beat 1, sop_err_count=1.
- Reset asserted on beat 2 of a 4-beat packet -> next cycle all dst_valid=0 and counters=0. The next sop packet goes to core 0.
